// File: rtl/cplx_pkg.sv
// Shared types and default sizes for the complex add/multiply scheduler.
// The structs describe the default-width configuration for clients that use fixed widths.
package cplx_pkg;

  localparam int CPLX_WIDTH      = 16;
  localparam int CPLX_NREQ       = 4;
  localparam int CPLX_FIFO_DEPTH = 4;
  localparam int CPLX_ID_W       = $clog2(CPLX_NREQ);
  localparam int CPLX_RW         = 2*CPLX_WIDTH + 1;

  typedef enum logic {
    CPLX_ADD = 1'b0,
    CPLX_MUL = 1'b1
  } cplx_op_e;

  typedef struct packed {
    logic signed [CPLX_WIDTH-1:0] re;
    logic signed [CPLX_WIDTH-1:0] im;
  } cplx_opnd_t;

  typedef struct packed {
    logic [CPLX_ID_W-1:0]      id;
    cplx_op_e                  op;
    logic signed [CPLX_RW-1:0] re;
    logic signed [CPLX_RW-1:0] im;
  } cplx_res_t;

endpackage

// File: rtl/cplx_alu_core.sv
// Two-stage complex add/multiply datapath: stage 1 registers operands, stage 2 registers the result.
// No stall input; the scheduler guarantees there is always room downstream.
module cplx_alu_core
  import cplx_pkg::*;
#(
  parameter int WIDTH = CPLX_WIDTH,
  parameter int IDW   = CPLX_ID_W
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  input  logic [IDW-1:0]          in_id,
  input  cplx_op_e                in_op,
  input  logic signed [WIDTH-1:0] in_a_re,
  input  logic signed [WIDTH-1:0] in_a_im,
  input  logic signed [WIDTH-1:0] in_b_re,
  input  logic signed [WIDTH-1:0] in_b_im,
  output logic                    out_valid,
  output logic [IDW-1:0]          out_id,
  output cplx_op_e                out_op,
  output logic signed [2*WIDTH:0] out_re,
  output logic signed [2*WIDTH:0] out_im
);

  localparam int RW = 2*WIDTH + 1;

  logic                    s1_valid_q, s1_valid_d;
  logic [IDW-1:0]          s1_id_q, s1_id_d;
  cplx_op_e                s1_op_q, s1_op_d;
  logic signed [WIDTH-1:0] s1_a_re_q, s1_a_re_d, s1_a_im_q, s1_a_im_d;
  logic signed [WIDTH-1:0] s1_b_re_q, s1_b_re_d, s1_b_im_q, s1_b_im_d;

  logic                    s2_valid_q, s2_valid_d;
  logic [IDW-1:0]          s2_id_q, s2_id_d;
  cplx_op_e                s2_op_q, s2_op_d;
  logic signed [RW-1:0]    s2_re_q, s2_re_d, s2_im_q, s2_im_d;

  logic signed [RW-1:0]    ar, ai, br, bi;

  always_comb begin
    s1_valid_d = in_valid;
    s1_id_d    = s1_id_q;
    s1_op_d    = s1_op_q;
    s1_a_re_d  = s1_a_re_q;
    s1_a_im_d  = s1_a_im_q;
    s1_b_re_d  = s1_b_re_q;
    s1_b_im_d  = s1_b_im_q;
    if (in_valid) begin
      s1_id_d   = in_id;
      s1_op_d   = in_op;
      s1_a_re_d = in_a_re;
      s1_a_im_d = in_a_im;
      s1_b_re_d = in_b_re;
      s1_b_im_d = in_b_im;
    end

    // RW bits hold the widest product sum, so truncating the multiply to RW is exact.
    ar = {{(RW-WIDTH){s1_a_re_q[WIDTH-1]}}, s1_a_re_q};
    ai = {{(RW-WIDTH){s1_a_im_q[WIDTH-1]}}, s1_a_im_q};
    br = {{(RW-WIDTH){s1_b_re_q[WIDTH-1]}}, s1_b_re_q};
    bi = {{(RW-WIDTH){s1_b_im_q[WIDTH-1]}}, s1_b_im_q};

    s2_valid_d = s1_valid_q;
    s2_id_d    = s2_id_q;
    s2_op_d    = s2_op_q;
    s2_re_d    = s2_re_q;
    s2_im_d    = s2_im_q;
    if (s1_valid_q) begin
      s2_id_d = s1_id_q;
      s2_op_d = s1_op_q;
      if (s1_op_q == CPLX_MUL) begin
        s2_re_d = ar * br - ai * bi;
        s2_im_d = ar * bi + ai * br;
      end else begin
        s2_re_d = ar + br;
        s2_im_d = ai + bi;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_id_q    <= '0;
      s1_op_q    <= CPLX_ADD;
      s1_a_re_q  <= '0;
      s1_a_im_q  <= '0;
      s1_b_re_q  <= '0;
      s1_b_im_q  <= '0;
      s2_valid_q <= 1'b0;
      s2_id_q    <= '0;
      s2_op_q    <= CPLX_ADD;
      s2_re_q    <= '0;
      s2_im_q    <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_id_q    <= s1_id_d;
      s1_op_q    <= s1_op_d;
      s1_a_re_q  <= s1_a_re_d;
      s1_a_im_q  <= s1_a_im_d;
      s1_b_re_q  <= s1_b_re_d;
      s1_b_im_q  <= s1_b_im_d;
      s2_valid_q <= s2_valid_d;
      s2_id_q    <= s2_id_d;
      s2_op_q    <= s2_op_d;
      s2_re_q    <= s2_re_d;
      s2_im_q    <= s2_im_d;
    end
  end

  assign out_valid = s2_valid_q;
  assign out_id    = s2_id_q;
  assign out_op    = s2_op_q;
  assign out_re    = s2_re_q;
  assign out_im    = s2_im_q;

endmodule

// File: rtl/cplx_alu_sched.sv
// Round-robin scheduler sharing one cplx_alu_core between NREQ requesters, with a credit-guarded
// show-ahead result FIFO. Define CPLX_SCHED_PRIO_EN to make requester 0 strict high priority.
// Handshakes: a request transfers on an edge where req_valid[i] & req_ready[i]; a result leaves
// on an edge where rsp_valid & rsp_ready. Requesters hold valid and operands until accepted.
module cplx_alu_sched
  import cplx_pkg::*;
#(
  parameter int WIDTH      = CPLX_WIDTH,
  parameter int NREQ       = CPLX_NREQ,
  parameter int FIFO_DEPTH = CPLX_FIFO_DEPTH
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [NREQ-1:0]                   req_valid,
  output logic [NREQ-1:0]                   req_ready,
  input  logic [NREQ-1:0]                   req_op,
  input  logic [NREQ-1:0][WIDTH-1:0]        req_a_re,
  input  logic [NREQ-1:0][WIDTH-1:0]        req_a_im,
  input  logic [NREQ-1:0][WIDTH-1:0]        req_b_re,
  input  logic [NREQ-1:0][WIDTH-1:0]        req_b_im,
  output logic                              rsp_valid,
  input  logic                              rsp_ready,
  output logic [$clog2(NREQ)-1:0]           rsp_id,
  output logic                              rsp_op,
  output logic signed [2*WIDTH:0]           rsp_re,
  output logic signed [2*WIDTH:0]           rsp_im,
  output logic                              busy
);

  localparam int IDW = $clog2(NREQ);
  localparam int RW  = 2*WIDTH + 1;
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int CW  = $clog2(FIFO_DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  typedef struct packed {
    logic [IDW-1:0]       id;
    cplx_op_e             op;
    logic signed [RW-1:0] re;
    logic signed [RW-1:0] im;
  } fifo_ent_t;

  logic [IDW-1:0] ptr_q, ptr_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [CW-1:0]  fill_q, fill_d;
  logic [AW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  fifo_ent_t      mem_q [FIFO_DEPTH];
  fifo_ent_t      mem_d [FIFO_DEPTH];
  fifo_ent_t      head;

  logic           issue_ok, gnt_found, issue, push, pop;
  logic [IDW-1:0] gnt_idx, cand_idx;
  int             cand;

  logic                 core_valid;
  logic [IDW-1:0]       core_id;
  cplx_op_e             core_op;
  logic signed [RW-1:0] core_re, core_im;

  // Credits count core and FIFO occupancy together, so a full FIFO can never be overrun.
  assign issue_ok = (cnt_q < DEPTH_C);

  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = 0;
    cand_idx  = '0;
    for (int i = 1; i <= NREQ; i++) begin
      cand     = (int'(ptr_q) + i) % NREQ;
      cand_idx = IDW'(cand);
      if (!gnt_found && req_valid[cand_idx]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand_idx;
      end
    end
`ifdef CPLX_SCHED_PRIO_EN
    if (req_valid[0]) begin
      gnt_found = 1'b1;
      gnt_idx   = '0;
    end
`endif
    // rst_n gating keeps req_ready low while reset is held.
    issue     = gnt_found && issue_ok && rst_n;
    req_ready = '0;
    if (issue) req_ready[gnt_idx] = 1'b1;
    ptr_d = ptr_q;
`ifdef CPLX_SCHED_PRIO_EN
    if (issue && (gnt_idx != '0)) ptr_d = gnt_idx;
`else
    if (issue) ptr_d = gnt_idx;
`endif
  end

  cplx_alu_core #(
    .WIDTH (WIDTH),
    .IDW   (IDW)
  ) u_core (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (issue),
    .in_id     (gnt_idx),
    .in_op     (cplx_op_e'(req_op[gnt_idx])),
    .in_a_re   (req_a_re[gnt_idx]),
    .in_a_im   (req_a_im[gnt_idx]),
    .in_b_re   (req_b_re[gnt_idx]),
    .in_b_im   (req_b_im[gnt_idx]),
    .out_valid (core_valid),
    .out_id    (core_id),
    .out_op    (core_op),
    .out_re    (core_re),
    .out_im    (core_im)
  );

  always_comb begin
    push     = core_valid;
    pop      = rsp_valid & rsp_ready;
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) begin
      mem_d[wr_ptr_q] = '{id: core_id, op: core_op, re: core_re, im: core_im};
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + AW'(1);
    fill_d = fill_q + CW'(push) - CW'(pop);
    cnt_d  = cnt_q + CW'(issue) - CW'(pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q    <= IDW'(NREQ - 1);
      cnt_q    <= '0;
      fill_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      ptr_q    <= ptr_d;
      cnt_q    <= cnt_d;
      fill_q   <= fill_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      mem_q    <= mem_d;
    end
  end

  assign head      = mem_q[rd_ptr_q];
  assign rsp_valid = (fill_q != '0);
  assign rsp_id    = head.id;
  assign rsp_op    = head.op;
  assign rsp_re    = head.re;
  assign rsp_im    = head.im;
  assign busy      = (cnt_q != '0);

endmodule

// File: tb/tb_cplx_alu_sched.sv
// Randomised bench for cplx_alu_sched: an arithmetic/arbitration reference model and result queue
// checked every cycle, plus directed latency, extreme-value, backpressure, reset and priority cases.
module tb_cplx_alu_sched;

  localparam int WIDTH      = 16;
  localparam int NREQ       = 4;
  localparam int FIFO_DEPTH = 4;
  localparam int IDW        = $clog2(NREQ);
  localparam int RW         = 2*WIDTH + 1;
  localparam int EW         = IDW + 1 + 2*RW;

  logic                       clk = 1'b0;
  logic                       rst_n = 1'b0;
  logic [NREQ-1:0]            req_valid, req_ready, req_op;
  logic [NREQ-1:0][WIDTH-1:0] req_a_re, req_a_im, req_b_re, req_b_im;
  logic                       rsp_valid, rsp_ready, rsp_op, busy;
  logic [IDW-1:0]             rsp_id;
  logic [RW-1:0]              rsp_re, rsp_im;

  int              n_checks = 0;
  int              n_errors = 0;
  logic [EW-1:0]   exp_q[$];
  logic [NREQ-1:0] hs_mask;
  int              m_cnt, m_fifo, m_p1, m_p2, m_ptr;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  cplx_alu_sched #(.WIDTH(WIDTH), .NREQ(NREQ), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_a_re  (req_a_re),
    .req_a_im  (req_a_im),
    .req_b_re  (req_b_re),
    .req_b_im  (req_b_im),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_op    (rsp_op),
    .rsp_re    (rsp_re),
    .rsp_im    (rsp_im),
    .busy      (busy)
  );

  task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [EW-1:0] model_result(input int id, input logic op,
      input logic [WIDTH-1:0] a_re, input logic [WIDTH-1:0] a_im,
      input logic [WIDTH-1:0] b_re, input logic [WIDTH-1:0] b_im);
    longint ar, ai, br, bi, re, im;
    ar = longint'($signed(a_re));
    ai = longint'($signed(a_im));
    br = longint'($signed(b_re));
    bi = longint'($signed(b_im));
    if (op) begin
      re = ar * br - ai * bi;
      im = ar * bi + ai * br;
    end else begin
      re = ar + br;
      im = ai + bi;
    end
    return {IDW'(id), op, re[RW-1:0], im[RW-1:0]};
  endfunction

  // ---------------- scoreboard / monitor ----------------
  always @(negedge clk) begin
    logic [NREQ-1:0] exp_ready, hs;
    logic            pop;
    logic [EW-1:0]   e;
    int              cand;
    if (!rst_n) begin
      exp_q.delete();
      m_cnt   = 0;
      m_fifo  = 0;
      m_p1    = 0;
      m_p2    = 0;
      m_ptr   = NREQ - 1;
      hs_mask = '0;
    end else begin
      exp_ready = '0;
      if (m_cnt < FIFO_DEPTH) begin
        for (int i = 1; i <= NREQ; i++) begin
          cand = (m_ptr + i) % NREQ;
          if (exp_ready == '0 && req_valid[cand]) exp_ready[cand] = 1'b1;
        end
`ifdef CPLX_SCHED_PRIO_EN
        if (req_valid[0]) begin
          exp_ready    = '0;
          exp_ready[0] = 1'b1;
        end
`endif
      end
      check_eq("req_ready", req_ready, exp_ready);
      check_eq("rsp_valid", rsp_valid, m_fifo != 0);
      check_eq("busy", busy, m_cnt != 0);
      hs  = req_valid & req_ready;
      pop = rsp_valid & rsp_ready;
      if (pop) begin
        if (exp_q.size() == 0) begin
          check_eq("rsp_unexpected", rsp_valid, 1'b0);
        end else begin
          e = exp_q.pop_front();
          check_eq("rsp_id", rsp_id, e[EW-1 -: IDW]);
          check_eq("rsp_op", rsp_op, e[2*RW]);
          check_eq("rsp_re", rsp_re, e[2*RW-1 -: RW]);
          check_eq("rsp_im", rsp_im, e[RW-1:0]);
        end
      end
      for (int i = 0; i < NREQ; i++) begin
        if (hs[i]) begin
          exp_q.push_back(model_result(i, req_op[i], req_a_re[i], req_a_im[i],
                                       req_b_re[i], req_b_im[i]));
`ifdef CPLX_SCHED_PRIO_EN
          if (i != 0) m_ptr = i;
`else
          m_ptr = i;
`endif
        end
      end
      m_fifo  = m_fifo + m_p2 - int'(pop);
      m_p2    = m_p1;
      m_p1    = (hs != '0) ? 1 : 0;
      m_cnt   = m_cnt + m_p1 - int'(pop);
      hs_mask = hs;
    end
  end

  // ---------------- driver tasks ----------------
  function automatic logic [WIDTH-1:0] rand_val();
    case ($urandom_range(7))
      0:       return 16'h8000;
      1:       return 16'h7fff;
      2:       return 16'hffff;
      default: return WIDTH'($urandom);
    endcase
  endfunction

  task automatic new_op(input int i);
    req_op[i]    = 1'($urandom_range(1));
    req_a_re[i]  = rand_val();
    req_a_im[i]  = rand_val();
    req_b_re[i]  = rand_val();
    req_b_im[i]  = rand_val();
    req_valid[i] = 1'b1;
  endtask

  task automatic drive_cycle(input logic [NREQ-1:0] en, input int p_valid, input int p_ready,
                             output logic [NREQ-1:0] acc);
    @(posedge clk); #1;
    acc = hs_mask;
    for (int i = 0; i < NREQ; i++) begin
      if (acc[i]) req_valid[i] = 1'b0;
      if (!req_valid[i] && en[i] && ($urandom_range(99) < p_valid)) new_op(i);
    end
    rsp_ready = ($urandom_range(99) < p_ready);
  endtask

  task automatic drain();
    for (int k = 0; k < 100; k++) begin
      @(posedge clk); #1;
      req_valid = req_valid & ~hs_mask;
      rsp_ready = 1'b1;
      if (req_valid == '0 && !busy) break;
    end
    check_eq("drain_idle", busy, 1'b0);
    check_eq("drain_queue_empty", exp_q.size(), 0);
    rsp_ready = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_rsp_valid"}, rsp_valid, 1'b0);
    check_eq({tag, "_rsp_id"}, rsp_id, '0);
    check_eq({tag, "_rsp_op"}, rsp_op, 1'b0);
    check_eq({tag, "_rsp_re"}, rsp_re, '0);
    check_eq({tag, "_rsp_im"}, rsp_im, '0);
    check_eq({tag, "_busy"}, busy, 1'b0);
    check_eq({tag, "_req_ready"}, req_ready, '0);
  endtask

  task automatic run_single(input string tag, input logic op,
      input logic [WIDTH-1:0] ar, input logic [WIDTH-1:0] ai,
      input logic [WIDTH-1:0] br, input logic [WIDTH-1:0] bi,
      input longint er, input longint ei);
    logic [RW-1:0] e_re, e_im;
    e_re = er[RW-1:0];
    e_im = ei[RW-1:0];
    @(posedge clk); #1;
    rsp_ready   = 1'b0;
    req_op[0]   = op;
    req_a_re[0] = ar;
    req_a_im[0] = ai;
    req_b_re[0] = br;
    req_b_im[0] = bi;
    req_valid[0] = 1'b1;
    #1;
    check_eq({tag, "_accept"}, req_ready[0], 1'b1);
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    check_eq({tag, "_lat_e0"}, rsp_valid, 1'b0);
    @(posedge clk); #1;
    check_eq({tag, "_lat_e1"}, rsp_valid, 1'b0);
    @(posedge clk); #1;
    check_eq({tag, "_lat_e2"}, rsp_valid, 1'b1);
    check_eq({tag, "_re"}, rsp_re, e_re);
    check_eq({tag, "_im"}, rsp_im, e_im);
    check_eq({tag, "_id"}, rsp_id, '0);
    check_eq({tag, "_op"}, rsp_op, op);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [NREQ-1:0] acc;
    int nacc, last, g0, g2;
    req_valid = '0;
    req_op    = '0;
    req_a_re  = '0;
    req_a_im  = '0;
    req_b_re  = '0;
    req_b_im  = '0;
    rsp_ready = 1'b0;

    #2;
    check_reset_outputs("rst0");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    run_single("single_mul", 1'b1, 16'd3, 16'd4, 16'd1, 16'hfffe, 64'sd11, -64'sd2);
    drain();
    run_single("ext_add", 1'b0, 16'h8000, 16'h8000, 16'h8000, 16'h8000, -64'sd65536, -64'sd65536);
    drain();
    run_single("ext_mul_re", 1'b1, 16'h8000, 16'h0000, 16'h8000, 16'h0000, 64'sd1073741824, 64'sd0);
    drain();
    run_single("ext_mul_cplx", 1'b1, 16'h8000, 16'h8000, 16'h8000, 16'h8000, 64'sd0, 64'sd2147483648);
    drain();

    nacc = 0;
    last = -1;
    for (int c = 0; c < 16; c++) begin
      drive_cycle('1, 100, 100, acc);
      for (int i = 0; i < NREQ; i++) begin
        if (acc[i]) begin
          nacc++;
          if (last >= 0) check_eq("rr_order", i, (last + 1) % NREQ);
          last = i;
        end
      end
    end
    check_eq("rr_throughput", nacc, 15);
    drain();

    nacc = 0;
    repeat (8) begin
      drive_cycle('1, 100, 0, acc);
      nacc += $countones(acc);
    end
    #1;
    check_eq("bp_accepts", nacc, FIFO_DEPTH);
    check_eq("bp_ready_low", req_ready, '0);
    rsp_ready = 1'b1;
    #1;
    check_eq("bp_pop_cycle_ready", req_ready, '0);
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    check_eq("bp_pop_no_accept", hs_mask, '0);
    #1;
    check_eq("bp_unlock", req_ready != '0, 1'b1);
    @(posedge clk); #1;
    check_eq("bp_new_accept", $countones(hs_mask), 1);
    req_valid = req_valid & ~hs_mask;
    drain();

    repeat (5) drive_cycle('1, 100, 0, acc);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("rst_mid");
    req_valid = '0;
    @(posedge clk); #1;
    for (int i = 0; i < NREQ; i++) new_op(i);
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    check_eq("rst_first_grant", req_ready, 4'b0001);
    @(posedge clk); #1;
    req_valid = req_valid & ~hs_mask;
    check_eq("rst_no_stale", rsp_valid, 1'b0);
    drain();

    g0 = 0;
    g2 = 0;
    repeat (12) begin
      drive_cycle(4'b0101, 100, 100, acc);
      g0 += int'(acc[0]);
      g2 += int'(acc[2]);
    end
`ifdef CPLX_SCHED_PRIO_EN
    check_eq("prio_req2_starved", g2, 0);
    check_eq("prio_req0_every_cycle", g0, 11);
`else
    check_eq("rr_alternate", ((g0 > g2) ? g0 - g2 : g2 - g0) <= 1, 1'b1);
    check_eq("rr_both_served", g0 + g2, 11);
`endif
    drain();

    repeat (400) drive_cycle('1, 40, 60, acc);
    drain();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
